bin_bcd_encoder: RTL and testbench



---
 rtl/bcd_pkg.sv | 14 +
 rtl/bcd_add3.sv | 12 +
 rtl/bin_bcd_encoder.sv | 116 +++++++++++
 tb/tb_bin_bcd_encoder.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the binary-to-BCD encoder.
// Contains the FSM state encoding, the BCD digit width and the display-blank code.
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      FINISH
   } state_t;

   localparam int         BCD_DIGIT_W = 4;
   localparam logic [3:0] BCD_BLANK   = 4'hF;

endpackage

// File: rtl/bcd_add3.sv
// Combinational double-dabble digit corrector: a digit of 5 or more gets +3.
// Purely combinational, with no latency and no backpressure.
module bcd_add3
   import bcd_pkg::*;
(
   input  logic [BCD_DIGIT_W-1:0] d_i,
   output logic [BCD_DIGIT_W-1:0] d_o
);

   assign d_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;

endmodule

// File: rtl/bin_bcd_encoder.sv
// Sequential binary-to-BCD encoder (shift-and-add-3), one input bit per clock, BIN_W+1 cycles START->DONE.
// START is ignored while BUSY; optional leading-zero blanking when BCD_BLANK_EN is defined.
module bin_bcd_encoder
   import bcd_pkg::*;
#(
   parameter int BIN_W  = 8,
   parameter int DIGITS = 3
) (
   input  logic                            CLK,
   input  logic                            RST,
   input  logic                            START,
   input  logic [BIN_W-1:0]                BIN,
   output logic                            BUSY,
   output logic                            DONE,
   output logic [BCD_DIGIT_W*DIGITS-1:0]   BCD,
   output logic                            OVF
);

   localparam int SCR_W = BCD_DIGIT_W * DIGITS;
   localparam int SR_W  = SCR_W + BIN_W;
   localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

   state_t               state_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [SR_W-1:0]      sr_q;
   logic [SR_W-1:0]      sr_d;
   logic [SCR_W-1:0]     scr_adj;
   logic [SCR_W-1:0]     bcd_d;
   logic [SCR_W-1:0]     bcd_q;
   logic                 sticky_q;
   logic                 busy_q;
   logic                 done_q;
   logic                 ovf_q;
   logic                 start_ok;

   for (genvar g = 0; g < DIGITS; g++) begin : g_dig
      bcd_add3 u_add3 (
         .d_i (sr_q[BIN_W + g*BCD_DIGIT_W +: BCD_DIGIT_W]),
         .d_o (scr_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
   end

   // Corrected scratch and the remaining binary bits shift left together.
   assign sr_d     = {scr_adj[SCR_W-2:0], sr_q[BIN_W-1:0], 1'b0};
   // FINISH is not busy, so a held START chains straight into the next conversion.
   assign start_ok = START && (state_q != SHIFT);

`ifdef BCD_BLANK_EN
   logic lead_zero;

   always_comb begin
      bcd_d     = sr_q[SR_W-1 -: SCR_W];
      lead_zero = !sticky_q;
      for (int i = DIGITS-1; i >= 1; i--) begin
         if (lead_zero && (bcd_d[i*BCD_DIGIT_W +: BCD_DIGIT_W] == '0)) begin
            bcd_d[i*BCD_DIGIT_W +: BCD_DIGIT_W] = BCD_BLANK;
         end else begin
            lead_zero = 1'b0;
         end
      end
   end
`else
   assign bcd_d = sr_q[SR_W-1 -: SCR_W];
`endif

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         sr_q     <= '0;
         sticky_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         bcd_q    <= '0;
         ovf_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            SHIFT: begin
               sr_q <= sr_d;
               if (scr_adj[SCR_W-1]) begin
                  sticky_q <= 1'b1;
               end
               if (cnt_q == '0) begin
                  state_q <= FINISH;
                  busy_q  <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            FINISH: begin
               done_q  <= 1'b1;
               bcd_q   <= bcd_d;
               ovf_q   <= sticky_q;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
         // Placed last so a new request overrides the FINISH->IDLE transition.
         if (start_ok) begin
            state_q  <= SHIFT;
            busy_q   <= 1'b1;
            sr_q     <= {{SCR_W{1'b0}}, BIN};
            cnt_q    <= CNT_LAST;
            sticky_q <= 1'b0;
         end
      end
   end

   assign BUSY = busy_q;
   assign DONE = done_q;
   assign BCD  = bcd_q;
   assign OVF  = ovf_q;

endmodule

// File: tb/tb_bin_bcd_encoder.sv
// Randomized and directed bench for bin_bcd_encoder: a 3-digit and a 2-digit instance,
// both checked every cycle against a decimal-arithmetic timeline model.
module tb_bin_bcd_encoder;

   localparam int BW = 8;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a, start_a, busy_a, done_a, ovf_a;
   logic [7:0]  bin_a;
   logic [11:0] bcd_a;
   logic        rst_b, start_b, busy_b, done_b, ovf_b;
   logic [7:0]  bin_b;
   logic [7:0]  bcd_b;

   bin_bcd_encoder #(.BIN_W(BW), .DIGITS(3)) u_dut_a (
      .CLK(clk), .RST(rst_a), .START(start_a), .BIN(bin_a),
      .BUSY(busy_a), .DONE(done_a), .BCD(bcd_a), .OVF(ovf_a)
   );

   bin_bcd_encoder #(.BIN_W(BW), .DIGITS(2)) u_dut_b (
      .CLK(clk), .RST(rst_b), .START(start_b), .BIN(bin_b),
      .BUSY(busy_b), .DONE(done_b), .BCD(bcd_b), .OVF(ovf_b)
   );

   int nvec = 0;
   int nerr = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: decimal digits of v by division, overflow by comparison with 10^d.
   function automatic logic [11:0] ref_bcd(input int v, input int d, input bit ov);
      int         m;
      logic [3:0] dig [3];
`ifdef BCD_BLANK_EN
      bit         lead;
`endif
      m = v;
      for (int i = 0; i < 3; i++) begin
         dig[i] = (i < d) ? 4'(m % 10) : 4'd0;
         m = m / 10;
      end
`ifdef BCD_BLANK_EN
      lead = !ov;
      for (int i = d-1; i >= 1; i--) begin
         if (lead && dig[i] == 4'd0) dig[i] = 4'hF;
         else lead = 1'b0;
      end
`else
      if (ov) m = 0;
`endif
      return {dig[2], dig[1], dig[0]};
   endfunction

   // Timeline model: an accepted request completes BIN_W+1 edges later.
   int          rem   [2] = '{0, 0};
   int          val   [2] = '{0, 0};
   logic        e_busy[2] = '{1'b0, 1'b0};
   logic        e_done[2] = '{1'b0, 1'b0};
   logic        e_ovf [2] = '{1'b0, 1'b0};
   logic [11:0] e_bcd [2] = '{12'h0, 12'h0};

   task automatic step(input int k, input logic r, input logic s, input logic [7:0] b);
      bit acc;
      int lim;
      lim = (k == 1) ? 100 : 1000;
      if (r) begin
         rem[k] = 0; e_busy[k] = 1'b0; e_done[k] = 1'b0; e_ovf[k] = 1'b0; e_bcd[k] = '0;
      end else begin
         acc       = s && (rem[k] <= 1);
         e_done[k] = (rem[k] == 1);
         if (rem[k] == 1) begin
            e_ovf[k] = (val[k] >= lim);
            e_bcd[k] = ref_bcd(val[k], (k == 1) ? 2 : 3, e_ovf[k]);
         end
         if (acc) begin
            rem[k] = BW + 1;
            val[k] = int'(b);
         end else if (rem[k] > 0) begin
            rem[k]--;
         end
         e_busy[k] = (rem[k] >= 2);
      end
   endtask

   always @(posedge clk) begin
      step(0, rst_a, start_a, bin_a);
      step(1, rst_b, start_b, bin_b);
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("busy_a", busy_a, e_busy[0]);
         check("done_a", done_a, e_done[0]);
         check("bcd_a",  bcd_a,  e_bcd[0]);
         check("ovf_a",  ovf_a,  e_ovf[0]);
         check("busy_b", busy_b, e_busy[1]);
         check("done_b", done_b, e_done[1]);
         check("bcd_b",  bcd_b,  e_bcd[1]);
         check("ovf_b",  ovf_b,  e_ovf[1]);
      end
   end

   // One conversion on DUT a (k=0) or b (k=1); lat counts edges from accept to DONE.
   task automatic conv(input bit k, input logic [7:0] v, output int lat, output int nbusy,
                       output logic [11:0] bcd, output logic ov);
      lat = -1; nbusy = 0; bcd = '0; ov = 1'b0;
      if (k) begin start_b = 1'b1; bin_b = v; end
      else   begin start_a = 1'b1; bin_a = v; end
      for (int i = 1; i <= 30 && lat < 0; i++) begin
         @(negedge clk);
         if (i == 1) begin
            if (k) begin start_b = 1'b0; bin_b = 8'($urandom); end
            else   begin start_a = 1'b0; bin_a = 8'($urandom); end
         end
         if (k ? busy_b : busy_a) nbusy++;
         if (k ? done_b : done_a) begin
            lat = i - 1;
            bcd = k ? {4'h0, bcd_b} : bcd_a;
            ov  = k ? ovf_b : ovf_a;
         end
      end
   endtask

   initial begin
      int          lat, nbusy, ndone;
      int          dpos [$];
      logic [11:0] dval [$];
      logic [11:0] r;
      logic        ov;
      logic [7:0]  pick;

      rst_a = 1'b1; rst_b = 1'b1;
      start_a = 1'b0; start_b = 1'b0;
      bin_a = 8'h0; bin_b = 8'h0;
      @(posedge clk);
      #1 chk_en = 1'b1;
      repeat (2) @(negedge clk);
      check("reset_busy", busy_a, 0);
      check("reset_bcd",  bcd_a,  0);
      check("reset_ovf",  ovf_b,  0);
      rst_a = 1'b0; rst_b = 1'b0;
      @(negedge clk);

      conv(0, 8'd255, lat, nbusy, r, ov);
      check("lat_255", lat, 9);
      check("busy_cycles_255", nbusy, 8);
      check("bcd_255", r, 12'h255);
      check("ovf_255", ov, 0);
      @(negedge clk);

      conv(0, 8'd0, lat, nbusy, r, ov);
`ifdef BCD_BLANK_EN
      check("bcd_0", r, 12'hFF0);
`else
      check("bcd_0", r, 12'h000);
`endif
      conv(0, 8'd99, lat, nbusy, r, ov);
`ifdef BCD_BLANK_EN
      check("bcd_99", r, 12'hF99);
`else
      check("bcd_99", r, 12'h099);
`endif

      conv(1, 8'd200, lat, nbusy, r, ov);
      check("bcd_200_d2", r, 12'h000);
      check("ovf_200_d2", ov, 1);
      conv(1, 8'd42, lat, nbusy, r, ov);
      check("bcd_42_d2", r, 12'h042);
      check("ovf_42_d2", ov, 0);

      // Second START during a conversion must be dropped.
      @(negedge clk);
      start_a = 1'b1; bin_a = 8'd123;
      @(negedge clk);
      start_a = 1'b0;
      repeat (3) @(negedge clk);
      start_a = 1'b1; bin_a = 8'd7;
      @(negedge clk);
      start_a = 1'b0;
      ndone = 0; r = '0;
      repeat (25) begin
         @(negedge clk);
         if (done_a) begin ndone++; r = bcd_a; end
      end
      check("midstart_ndone", ndone, 1);
      check("midstart_bcd", r, 12'h123);

      // Reset four edges into a conversion.
      start_a = 1'b1; bin_a = 8'd200;
      @(negedge clk);
      start_a = 1'b0;
      repeat (3) @(negedge clk);
      rst_a = 1'b1;
      @(negedge clk);
      check("abort_busy", busy_a, 0);
      check("abort_bcd",  bcd_a,  0);
      check("abort_ovf",  ovf_a,  0);
      rst_a = 1'b0;
      ndone = 0;
      repeat (15) begin
         @(negedge clk);
         if (done_a) ndone++;
      end
      check("abort_no_done", ndone, 0);

      // START held high: back-to-back conversions of 1, 2, 3.
      start_a = 1'b1; bin_a = 8'd1;
      for (int i = 1; i <= 35; i++) begin
         @(negedge clk);
         if (i == 9)  bin_a = 8'd2;
         if (i == 18) bin_a = 8'd3;
         if (i == 19) start_a = 1'b0;
         if (done_a) begin dpos.push_back(i); dval.push_back(bcd_a); end
      end
      check("b2b_count", dpos.size(), 3);
      if (dpos.size() == 3) begin
         check("b2b_gap1", dpos[1] - dpos[0], 9);
         check("b2b_gap2", dpos[2] - dpos[1], 9);
`ifdef BCD_BLANK_EN
         check("b2b_v1", dval[0], 12'hFF1);
         check("b2b_v2", dval[1], 12'hFF2);
         check("b2b_v3", dval[2], 12'hFF3);
`else
         check("b2b_v1", dval[0], 12'h001);
         check("b2b_v2", dval[1], 12'h002);
         check("b2b_v3", dval[2], 12'h003);
`endif
      end

      // Random traffic with occasional resets, checked by the per-cycle compare.
      repeat (600) begin
         @(negedge clk);
         start_a = ($urandom_range(0, 2) == 0);
         start_b = ($urandom_range(0, 2) == 0);
         case ($urandom_range(0, 5))
            0: pick = 8'd0;
            1: pick = 8'd99;
            2: pick = 8'd100;
            3: pick = 8'd255;
            default: pick = 8'($urandom);
         endcase
         bin_a = pick;
         bin_b = 8'($urandom);
         rst_a = ($urandom_range(0, 79) == 0);
         rst_b = ($urandom_range(0, 79) == 0);
      end
      @(negedge clk);
      start_a = 1'b0; start_b = 1'b0; rst_a = 1'b0; rst_b = 1'b0;
      repeat (12) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
